// File: rtl/alu_sched_if.sv
// alu_sched_if: requester-side request/response bundle shared by requesters and the scheduler
interface alu_sched_if #(
  parameter int NUM_REQ      = 4,
  parameter int OPCODE_WIDTH = 2,
  parameter int DATA_WIDTH   = 3
);
  logic [NUM_REQ-1:0]                    req_valid;
  logic [NUM_REQ-1:0]                    req_ready;
  logic [NUM_REQ*(OPCODE_WIDTH+1)-1:0]   req_opcode;
  logic [NUM_REQ*(DATA_WIDTH+1)-1:0]     req_op1;
  logic [NUM_REQ*(DATA_WIDTH+1)-1:0]     req_op2;
  logic [NUM_REQ-1:0]                    rsp_valid;
  logic [NUM_REQ-1:0]                    rsp_ready;
  logic [DATA_WIDTH:0]                   rsp_result;
  logic                                  rsp_carry;
  logic                                  rsp_zero;
  modport master (
    output req_valid, req_opcode, req_op1, req_op2, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero
  );
  modport slave (
    input  req_valid, req_opcode, req_op1, req_op2, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero
  );
endinterface

// File: rtl/alu_sched.sv
// alu_sched: round-robin sharing of one registered ALU among NUM_REQ requesters; ALU_SCHED_WDOG_EN adds a response watchdog
module alu_sched #(
  parameter int NUM_REQ      = 4,
  parameter int OPCODE_WIDTH = 2,
  parameter int DATA_WIDTH   = 3,
  parameter int RSP_TIMEOUT  = 15
) (
  input  logic                  clk,
  input  logic                  rstn,
  alu_sched_if.slave            bus,
  output logic [OPCODE_WIDTH:0] alu_opcode,
  output logic [DATA_WIDTH:0]   alu_op1,
  output logic [DATA_WIDTH:0]   alu_op2,
  input  logic [DATA_WIDTH:0]   alu_result,
  input  logic                  alu_carry,
  input  logic                  alu_zero,
  output logic                  busy,
  output logic                  err_timeout
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int OW = OPCODE_WIDTH + 1;
  localparam int DW = DATA_WIDTH + 1;
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2, RESP = 2'd3;
  logic [1:0]         state;
  logic [GW-1:0]      last_grant;
  logic [GW-1:0]      gnt;
  logic [GW-1:0]      idx;
  logic               gnt_ok;
  logic               rsp_hit;
  logic               wdog_hit;
  logic [NUM_REQ-1:0] one;
  assign one           = {{(NUM_REQ-1){1'b0}}, 1'b1};
  assign busy          = state != IDLE;
  assign rsp_hit       = bus.rsp_ready[last_grant];
  assign bus.req_ready = (state == IDLE && gnt_ok) ? one << gnt : '0;
  assign bus.rsp_valid = (state == RESP) ? one << last_grant : '0;
  // scan from the farthest lane down to last_grant+1 so the nearest valid lane wins
  always_comb begin
    gnt    = last_grant;
    gnt_ok = 1'b0;
    idx    = last_grant;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = GW'((int'(last_grant) + k) % NUM_REQ);
      if (bus.req_valid[idx]) begin
        gnt    = idx;
        gnt_ok = 1'b1;
      end
    end
  end
  // operation sequencing: grant, issue to the ALU, capture its outputs, hold the response
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      last_grant     <= GW'(NUM_REQ - 1);
      alu_opcode     <= '0;
      alu_op1        <= '0;
      alu_op2        <= '0;
      bus.rsp_result <= '0;
      bus.rsp_carry  <= 1'b0;
      bus.rsp_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (gnt_ok) begin
          state      <= ISSUE;
          last_grant <= gnt;
          alu_opcode <= bus.req_opcode[int'(gnt)*OW +: OW];
          alu_op1    <= bus.req_op1[int'(gnt)*DW +: DW];
          alu_op2    <= bus.req_op2[int'(gnt)*DW +: DW];
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          state          <= RESP;
          bus.rsp_result <= alu_result;
          bus.rsp_carry  <= alu_carry;
          bus.rsp_zero   <= alu_zero;
        end
        default: if (rsp_hit || wdog_hit) state <= IDLE;
      endcase
    end
  end
`ifdef ALU_SCHED_WDOG_EN
  localparam int WW = $clog2(RSP_TIMEOUT + 1);
  logic [WW-1:0] wcnt;
  assign wdog_hit = wcnt == WW'(RSP_TIMEOUT - 1);
  // count cycles spent in RESP; zero outside it so every RESP entry starts fresh
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wcnt        <= '0;
      err_timeout <= 1'b0;
    end else begin
      wcnt        <= (state == RESP) ? wcnt + 1'b1 : '0;
      err_timeout <= state == RESP && !rsp_hit && wdog_hit;
    end
  end
`else
  assign wdog_hit    = 1'b0;
  assign err_timeout = 1'b0;
`endif
endmodule
